// File: rtl/sparse_mul_pkg.sv
// Shared definitions for the sparse ternary polynomial multiplier:
// width helpers, the control FSM encoding and the modular negation.
package sparse_mul_pkg;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    function automatic int calc_w(input int h, input int cores);
        return (h + cores - 1) / cores;
    endfunction

    // Address width that never collapses to zero bits for single-entry RAMs.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    localparam int N_DEF         = 1024;
    localparam int H_DEF         = 384;
    localparam int CORE_NUM_DEF  = 8;
    localparam int POS_WIDTH_DEF = clog2(N_DEF);
    localparam int ENTRY_DEF     = POS_WIDTH_DEF + 1;
    localparam int W_DEF         = calc_w(H_DEF, CORE_NUM_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Additive inverse in Z_q; zero stays zero so results remain in [0,q).
    function automatic int unsigned mod_sub_q(input int unsigned t, input int unsigned q);
        return (t == 32'd0) ? 32'd0 : q - t;
    endfunction

endpackage

// File: rtl/sparse_mul_lane.sv
// One multiplier lane: private replica of the dense polynomial RAM, source
// index / wrap derivation and signed term generation for two columns per cycle.
module sparse_mul_lane
    import sparse_mul_pkg::*;
#(
    parameter int N           = 1024,
    parameter int Q           = 251,
    parameter int COEFF_WIDTH = 8,
    localparam int POS_WIDTH  = clog2(N),
    localparam int PA_W       = POS_WIDTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     poly_wr_en_i,
    input  logic [PA_W-1:0]          poly_wr_addr_i,
    input  logic [2*COEFF_WIDTH-1:0] poly_wr_data_i,
    input  logic                     en_i,
    input  logic                     active_i,
    input  logic                     sign_i,
    input  logic [POS_WIDTH-1:0]     pos_i,
    input  logic [PA_W-1:0]          m_i,
    output logic [COEFF_WIDTH-1:0]   term0_o,
    output logic [COEFF_WIDTH-1:0]   term1_o
);

    logic [2*COEFF_WIDTH-1:0] mem [N/2];

    logic [POS_WIDTH-1:0]     j0, j1, src0, src1;
    logic                     neg0_d, neg1_d;
    logic [2*COEFF_WIDTH-1:0] rd0_q, rd1_q;
    logic                     hi0_q, hi1_q, neg0_q, neg1_q, act_q;
    logic [COEFF_WIDTH-1:0]   t0, t1, term0_d, term1_d, term0_q, term1_q;

    always_ff @(posedge clk) begin
        if (poly_wr_en_i) begin
            mem[poly_wr_addr_i] <= poly_wr_data_i;
        end
    end

    // Subtraction modulo N falls out of the POS_WIDTH-bit wraparound.
    always_comb begin
        j0     = {m_i, 1'b0};
        j1     = {m_i, 1'b1};
        src0   = j0 - pos_i;
        src1   = j1 - pos_i;
        neg0_d = sign_i ^ (j0 < pos_i);
        neg1_d = sign_i ^ (j1 < pos_i);
    end

    always_ff @(posedge clk) begin
        rd0_q <= mem[src0[POS_WIDTH-1:1]];
        rd1_q <= mem[src1[POS_WIDTH-1:1]];
    end

    always_comb begin
        t0      = hi0_q ? rd0_q[2*COEFF_WIDTH-1:COEFF_WIDTH] : rd0_q[COEFF_WIDTH-1:0];
        t1      = hi1_q ? rd1_q[2*COEFF_WIDTH-1:COEFF_WIDTH] : rd1_q[COEFF_WIDTH-1:0];
        term0_d = '0;
        term1_d = '0;
        if (act_q) begin
            term0_d = neg0_q ? COEFF_WIDTH'(mod_sub_q(32'(t0), 32'(Q))) : t0;
            term1_d = neg1_q ? COEFF_WIDTH'(mod_sub_q(32'(t1), 32'(Q))) : t1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= 1'b0;
            hi0_q   <= 1'b0;
            hi1_q   <= 1'b0;
            neg0_q  <= 1'b0;
            neg1_q  <= 1'b0;
            term0_q <= '0;
            term1_q <= '0;
        end else begin
            act_q   <= en_i & active_i;
            hi0_q   <= src0[0];
            hi1_q   <= src1[0];
            neg0_q  <= neg0_d;
            neg1_q  <= neg1_d;
            term0_q <= term0_d;
            term1_q <= term1_d;
        end
    end

    assign term0_o = term0_q;
    assign term1_o = term1_q;

endmodule

// File: rtl/sparse_mul_param.sv
// Sparse ternary polynomial multiplier r (+)= a*s mod (x^N+1) mod Q: control FSM,
// position RAM, lane array, adder tree with exact mod-Q reduction and result RAM.
module sparse_mul_param
    import sparse_mul_pkg::*;
#(
    parameter int N           = 1024,
    parameter int H           = 384,
    parameter int Q           = 251,
    parameter int CORE_NUM    = 8,
    parameter int COEFF_WIDTH = 8,
    localparam int POS_WIDTH  = clog2(N),
    localparam int ENTRY      = POS_WIDTH + 1,
    localparam int W          = calc_w(H, CORE_NUM),
    localparam int PA_W       = POS_WIDTH - 1,
    localparam int WA_W       = addr_width(W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      acc_mode,
    output logic                      busy,
    output logic                      done,
    input  logic                      ram_poly_wr_en,
    input  logic [PA_W-1:0]           ram_poly_wr_addr,
    input  logic [2*COEFF_WIDTH-1:0]  ram_poly_data_in,
    input  logic                      ram_pos_wr_en,
    input  logic [WA_W-1:0]           ram_pos_wr_addr,
    input  logic [ENTRY*CORE_NUM-1:0] ram_pos_data_in,
    input  logic                      i_ram_res_rd_en,
    input  logic [PA_W-1:0]           i_ram_res_rd_addr,
    output logic [2*COEFF_WIDTH-1:0]  o_ram_res_data_out,
    output state_e                    dbg_state_o
);

    localparam int SUM_W = clog2((CORE_NUM + 1) * Q);
    localparam logic [PA_W-1:0] M_LAST     = PA_W'(N / 2 - 1);
    localparam logic [WA_W-1:0] W_LAST     = WA_W'(W - 1);
    localparam logic [PA_W-1:0] DRAIN_LAST = PA_W'(3);

    state_e          state_q, state_d;
    logic [PA_W-1:0] m_q, m_d;
    logic [WA_W-1:0] w_q, w_d;
    logic            done_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = acc_mode ? RUN : CLEAR;
                    m_d     = '0;
                    w_d     = '0;
                end
            end
            CLEAR: begin
                m_d = m_q + 1'b1;
                if (m_q == M_LAST) begin
                    state_d = RUN;
                    m_d     = '0;
                end
            end
            RUN: begin
                m_d = m_q + 1'b1;
                if (m_q == M_LAST) begin
                    m_d = '0;
                    w_d = w_q + 1'b1;
                    if (w_q == W_LAST) begin
                        state_d = DRAIN;
                        w_d     = '0;
                    end
                end
            end
            DRAIN: begin
                m_d = m_q + 1'b1;
                if (m_q == DRAIN_LAST) begin
                    state_d = DONE;
                    m_d     = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done is registered off the DONE state, so busy drops on the same edge done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            w_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            w_q     <= w_d;
            done_q  <= (state_q == DONE);
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign dbg_state_o = state_q;

    logic [ENTRY*CORE_NUM-1:0] pos_mem [W];
    logic [ENTRY*CORE_NUM-1:0] pos_word;

    always_ff @(posedge clk) begin
        if (ram_pos_wr_en && !busy && (int'(ram_pos_wr_addr) < W)) begin
            pos_mem[ram_pos_wr_addr] <= ram_pos_data_in;
        end
    end

    assign pos_word = pos_mem[w_q];

    logic                   run_en, poly_we;
    logic [COEFF_WIDTH-1:0] term0 [CORE_NUM];
    logic [COEFF_WIDTH-1:0] term1 [CORE_NUM];

    assign run_en  = (state_q == RUN);
    assign poly_we = ram_poly_wr_en & ~busy;

    for (genvar k = 0; k < CORE_NUM; k++) begin : g_lane
        logic [ENTRY-1:0] entry;
        logic             active;
        assign entry  = pos_word[k*ENTRY +: ENTRY];
        // Padding slots of the last pass are masked regardless of RAM contents.
        assign active = (int'(w_q) * CORE_NUM + k) < H;

        sparse_mul_lane #(
            .N          (N),
            .Q          (Q),
            .COEFF_WIDTH(COEFF_WIDTH)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .poly_wr_en_i  (poly_we),
            .poly_wr_addr_i(ram_poly_wr_addr),
            .poly_wr_data_i(ram_poly_data_in),
            .en_i          (run_en),
            .active_i      (active),
            .sign_i        (entry[ENTRY-1]),
            .pos_i         (entry[POS_WIDTH-1:0]),
            .m_i           (m_q),
            .term0_o       (term0[k]),
            .term1_o       (term1[k])
        );
    end

    logic                     v_s1_q, v_s2_q, v_s3_q;
    logic [PA_W-1:0]          m_s1_q, m_s2_q, m_s3_q;
    logic [2*COEFF_WIDTH-1:0] sum_d, sum_q, res_rd_q;
    logic [SUM_W-1:0]         acc0, acc1;

    always_comb begin
        acc0 = SUM_W'(res_rd_q[COEFF_WIDTH-1:0]);
        acc1 = SUM_W'(res_rd_q[2*COEFF_WIDTH-1:COEFF_WIDTH]);
        for (int k = 0; k < CORE_NUM; k++) begin
            acc0 = acc0 + SUM_W'(term0[k]);
            acc1 = acc1 + SUM_W'(term1[k]);
        end
        sum_d = {COEFF_WIDTH'(acc1 % SUM_W'(Q)), COEFF_WIDTH'(acc0 % SUM_W'(Q))};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1_q <= 1'b0;
            v_s2_q <= 1'b0;
            v_s3_q <= 1'b0;
            m_s1_q <= '0;
            m_s2_q <= '0;
            m_s3_q <= '0;
            sum_q  <= '0;
        end else begin
            v_s1_q <= run_en;
            v_s2_q <= v_s1_q;
            v_s3_q <= v_s2_q;
            m_s1_q <= m_q;
            m_s2_q <= m_s1_q;
            m_s3_q <= m_s2_q;
            sum_q  <= sum_d;
        end
    end

    logic [2*COEFF_WIDTH-1:0] res_mem [N/2];
    logic                     res_we, res_rd_en;
    logic [PA_W-1:0]          res_wa, res_ra;
    logic [2*COEFF_WIDTH-1:0] res_wd;

    always_comb begin
        res_we = 1'b0;
        res_wa = m_s3_q;
        res_wd = sum_q;
        if (state_q == CLEAR) begin
            res_we = 1'b1;
            res_wa = m_q;
            res_wd = '0;
        end else if (v_s3_q) begin
            res_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res_we) begin
            res_mem[res_wa] <= res_wd;
        end
    end

    // The pipeline owns the read port while a pass is in flight.
    assign res_ra    = v_s1_q ? m_s1_q : i_ram_res_rd_addr;
    assign res_rd_en = v_s1_q | i_ram_res_rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_rd_q <= '0;
        end else if (res_rd_en) begin
            res_rd_q <= res_mem[res_ra];
        end
    end

    assign o_ram_res_data_out = res_rd_q;

endmodule

// File: tb/tb_sparse_mul_param.sv
// Self-checking bench for sparse_mul_param on a small ring (N=64, H=20, 8 lanes)
// against a direct convolution model of a*s mod (x^N+1) mod Q.
module tb_sparse_mul_param;
    import sparse_mul_pkg::*;

    localparam int N     = 64;
    localparam int H     = 20;
    localparam int Q     = 251;
    localparam int CORES = 8;
    localparam int CW    = 8;
    localparam int PW    = 6;
    localparam int ENTRY = PW + 1;
    localparam int W     = (H + CORES - 1) / CORES;
    localparam int PA_W  = PW - 1;
    localparam int WA_W  = 2;
    localparam int HALF  = N / 2;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  acc_mode;
    logic                  busy;
    logic                  done;
    logic                  ram_poly_wr_en;
    logic [PA_W-1:0]       ram_poly_wr_addr;
    logic [2*CW-1:0]       ram_poly_data_in;
    logic                  ram_pos_wr_en;
    logic [WA_W-1:0]       ram_pos_wr_addr;
    logic [ENTRY*CORES-1:0] ram_pos_data_in;
    logic                  i_ram_res_rd_en;
    logic [PA_W-1:0]       i_ram_res_rd_addr;
    logic [2*CW-1:0]       o_ram_res_data_out;
    state_e                dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [2*CW-1:0] exp_q[$];

    int a_m[N];
    int pos_m[H];
    bit sgn_m[H];
    int r_m[N];

    sparse_mul_param #(
        .N(N), .H(H), .Q(Q), .CORE_NUM(CORES), .COEFF_WIDTH(CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .acc_mode          (acc_mode),
        .busy              (busy),
        .done              (done),
        .ram_poly_wr_en    (ram_poly_wr_en),
        .ram_poly_wr_addr  (ram_poly_wr_addr),
        .ram_poly_data_in  (ram_poly_data_in),
        .ram_pos_wr_en     (ram_pos_wr_en),
        .ram_pos_wr_addr   (ram_pos_wr_addr),
        .ram_pos_data_in   (ram_pos_data_in),
        .i_ram_res_rd_en   (i_ram_res_rd_en),
        .i_ram_res_rd_addr (i_ram_res_rd_addr),
        .o_ram_res_data_out(o_ram_res_data_out),
        .dbg_state_o       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // r = (acc ? r : 0) + a*s, computed as a product sum over a's index.
    task automatic model_run(input bit acc);
        if (!acc) begin
            for (int i = 0; i < N; i++) r_m[i] = 0;
        end
        for (int h = 0; h < H; h++) begin
            for (int i = 0; i < N; i++) begin
                int idx;
                int c;
                idx = i + pos_m[h];
                c   = sgn_m[h] ? -a_m[i] : a_m[i];
                if (idx >= N) begin
                    idx = idx - N;
                    c   = -c;
                end
                r_m[idx] = (((r_m[idx] + c) % Q) + Q) % Q;
            end
        end
    endtask

    task automatic load_poly();
        for (int m = 0; m < HALF; m++) begin
            @(negedge clk);
            ram_poly_wr_en   = 1'b1;
            ram_poly_wr_addr = PA_W'(m);
            ram_poly_data_in = {CW'(a_m[2*m+1]), CW'(a_m[2*m])};
        end
        @(negedge clk);
        ram_poly_wr_en = 1'b0;
    endtask

    task automatic load_pos(input bit random_garbage);
        for (int w = 0; w < W; w++) begin
            logic [ENTRY*CORES-1:0] word;
            word = '0;
            for (int k = 0; k < CORES; k++) begin
                int g;
                logic [ENTRY-1:0] e;
                g = w * CORES + k;
                if (g < H) e = {sgn_m[g], PW'(pos_m[g])};
                else if (random_garbage) e = {1'($urandom_range(1, 0)), PW'($urandom_range(N - 1, 0))};
                else e = {1'b0, PW'(3)};
                word[k*ENTRY +: ENTRY] = e;
            end
            @(negedge clk);
            ram_pos_wr_en   = 1'b1;
            ram_pos_wr_addr = WA_W'(w);
            ram_pos_data_in = word;
        end
        @(negedge clk);
        ram_pos_wr_en = 1'b0;
    endtask

    // Starts an operation and measures edges from the accepting edge to done.
    task automatic run_op(input bit acc, input bit perturb);
        int cyc;
        bit seen;
        int exp_cyc;
        exp_cyc = (acc ? 0 : HALF) + W * HALF + 5;
        @(negedge clk);
        start    = 1'b1;
        acc_mode = acc;
        @(posedge clk);
        #1;
        start    = 1'b0;
        acc_mode = ~acc;
        check("busy_after_start", 32'(busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (perturb && cyc == 40) begin
                start            = 1'b1;
                ram_pos_wr_en    = 1'b1;
                ram_pos_wr_addr  = '0;
                ram_pos_data_in  = {ENTRY*CORES{1'b1}};
                ram_poly_wr_en   = 1'b1;
                ram_poly_wr_addr = '0;
                ram_poly_data_in = 16'h1234;
            end else if (perturb && cyc == 41) begin
                start          = 1'b0;
                ram_pos_wr_en  = 1'b0;
                ram_poly_wr_en = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        check("done_latency", 32'(cyc), 32'(exp_cyc));
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_width", 32'(done), 32'd0);
        acc_mode = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int m = 0; m < HALF; m++) begin
            @(negedge clk);
            i_ram_res_rd_en   = 1'b1;
            i_ram_res_rd_addr = PA_W'(m);
            exp_q.push_back({CW'(r_m[2*m+1]), CW'(r_m[2*m])});
            @(posedge clk);
            #1;
            check($sformatf("%s_word%0d", tag, m), 32'(o_ram_res_data_out), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
        i_ram_res_rd_en = 1'b0;
    endtask

    initial begin
        int done_seen;
        rst_n             = 1'b0;
        start             = 1'b0;
        acc_mode          = 1'b0;
        ram_poly_wr_en    = 1'b0;
        ram_poly_wr_addr  = '0;
        ram_poly_data_in  = '0;
        ram_pos_wr_en     = 1'b0;
        ram_pos_wr_addr   = '0;
        ram_pos_data_in   = '0;
        i_ram_res_rd_en   = 1'b0;
        i_ram_res_rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dout", 32'(o_ram_res_data_out), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        // a[i] = i mod Q, s = x^1 + ... + x^20, padding lanes hold pos=3/sign=0
        for (int i = 0; i < N; i++) a_m[i] = i % Q;
        for (int h = 0; h < H; h++) begin
            pos_m[h] = h + 1;
            sgn_m[h] = 1'b0;
        end
        load_poly();
        load_pos(1'b0);
        run_op(1'b0, 1'b0);
        model_run(1'b0);
        read_all("seq");

        // random dense a, mixed signs, boundary positions 0, N-1 and -x^1
        for (int i = 0; i < N; i++) a_m[i] = int'($urandom_range(Q - 1, 0));
        pos_m[0] = 0;     sgn_m[0] = 1'b0;
        pos_m[1] = N - 1; sgn_m[1] = 1'b1;
        pos_m[2] = 1;     sgn_m[2] = 1'b1;
        for (int h = 3; h < H; h++) begin
            pos_m[h] = int'($urandom_range(N - 1, 0));
            sgn_m[h] = 1'($urandom_range(1, 0));
        end
        load_poly();
        load_pos(1'b1);
        run_op(1'b0, 1'b0);
        model_run(1'b0);
        read_all("rand");
        run_op(1'b1, 1'b0);
        model_run(1'b1);
        read_all("acc1");
        run_op(1'b1, 1'b0);
        model_run(1'b1);
        read_all("acc2");

        // reset pulled in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (HALF + 20) @(negedge clk);
        check("mid_state_run", 32'(dbg_state), 32'(RUN));
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_done", 32'(done), 32'd0);
        check("mid_reset_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("no_activity_after_reset", 32'(done_seen), 32'd0);
        run_op(1'b0, 1'b0);
        model_run(1'b0);
        read_all("post_reset");

        // start and RAM writes while busy must not disturb the run
        run_op(1'b0, 1'b1);
        model_run(1'b0);
        read_all("perturbed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
